// File: rtl/corrimiento_pkg.sv
// corrimiento_pkg: shared op encoding and sequencer states for the shift sequencer.
package corrimiento_pkg;
  typedef enum logic [2:0] {
    OP_TRANSFER = 3'b000,
    OP_SHL      = 3'b001,
    OP_SHR      = 3'b010,
    OP_ZERO     = 3'b011,
    OP_ROL      = 3'b100,
    OP_ROR      = 3'b101,
    OP_ASL      = 3'b110,
    OP_ASR      = 3'b111
  } op_corr_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } estado_sec_t;
  function automatic logic sale_por_izq(input op_corr_t op);
    return op inside {OP_SHL, OP_ASL, OP_ROL};
  endfunction
  function automatic logic sale_por_der(input op_corr_t op);
    return op inside {OP_SHR, OP_ASR, OP_ROR};
  endfunction
endpackage

// File: rtl/unidad_corrimiento.sv
// unidad_corrimiento: combinational shifter/rotator, F shifted by D according to op H.
module unidad_corrimiento
  import corrimiento_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_f,
  input  op_corr_t             i_h,
  input  logic [$clog2(N)-1:0] i_d,
  output logic [N-1:0]         o_s
);
  logic [2*N-1:0]      w_izq;
  logic [2*N-1:0]      w_der;
  logic signed [N-1:0] w_fs;
  // Rotations come from the doubled word so d = 0 needs no special case.
  assign w_izq = {i_f, i_f} << i_d;
  assign w_der = {i_f, i_f} >> i_d;
  assign w_fs  = i_f;
  always_comb begin
    o_s = i_f;
    case (i_h)
      OP_ZERO:        o_s = '0;
      OP_SHL, OP_ASL: o_s = i_f << i_d;
      OP_SHR:         o_s = i_f >> i_d;
      OP_ASR:         o_s = w_fs >>> i_d;
      OP_ROL:         o_s = w_izq[2*N-1:N];
      OP_ROR:         o_s = w_der[N-1:0];
      default:        o_s = i_f;
    endcase
  end
endmodule

// File: rtl/secuenciador_corrimiento.sv
// secuenciador_corrimiento: multi-cycle shift command sequencer around unidad_corrimiento.
// Optional sticky asl overflow output res_ovf enabled by CORRIMIENTO_OVF_EN.
module secuenciador_corrimiento
  import corrimiento_pkg::*;
#(
  parameter int N  = 4,
  parameter int RW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_load,
  input  logic [N-1:0]         cmd_dato,
  input  logic [2:0]           cmd_op,
  input  logic [$clog2(N)-1:0] cmd_d,
  input  logic [RW-1:0]        cmd_rep,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N-1:0]         res_dato,
  output logic                 res_carry,
  output logic                 res_cero
`ifdef CORRIMIENTO_OVF_EN
  ,
  output logic                 res_ovf
`endif
);
  localparam int DW = $clog2(N);
  estado_sec_t r_estado, w_estado_sig;
  logic [N-1:0]  r_acc, w_acc_sig, w_shift;
  op_corr_t      r_op, w_op_sig;
  logic [DW-1:0] r_d, w_d_sig;
  logic [RW-1:0] r_cnt, w_cnt_sig;
  logic          r_carry, w_carry_sig, w_carry_it;
  logic [N:0]    w_ext_izq, w_ext_der;
`ifdef CORRIMIENTO_OVF_EN
  logic                r_ovf, w_ovf_sig, w_ovf_it;
  logic signed [N-1:0] w_sl;
  logic [N-1:0]        w_vuelta;
`endif

  unidad_corrimiento #(.N(N)) u_unidad (
    .i_f(r_acc),
    .i_h(r_op),
    .i_d(r_d),
    .o_s(w_shift)
  );

  // A guard bit on either side catches the bit leaving the word; it stays 0 for d = 0.
  assign w_ext_izq  = {1'b0, r_acc} << r_d;
  assign w_ext_der  = {r_acc, 1'b0} >> r_d;
  assign w_carry_it = sale_por_izq(r_op) ? w_ext_izq[N] :
                      sale_por_der(r_op) ? w_ext_der[0] : 1'b0;
`ifdef CORRIMIENTO_OVF_EN
  // Overflow when shifting back arithmetically does not restore the original value.
  assign w_sl     = r_acc << r_d;
  assign w_vuelta = w_sl >>> r_d;
  assign w_ovf_it = (r_op == OP_ASL) && (w_vuelta != r_acc);
`endif

  always_comb begin
    w_estado_sig = r_estado;
    w_acc_sig    = r_acc;
    w_op_sig     = r_op;
    w_d_sig      = r_d;
    w_cnt_sig    = r_cnt;
    w_carry_sig  = r_carry;
`ifdef CORRIMIENTO_OVF_EN
    w_ovf_sig    = r_ovf;
`endif
    case (r_estado)
      IDLE: if (cmd_valid) begin
        w_op_sig     = op_corr_t'(cmd_op);
        w_d_sig      = cmd_d;
        w_cnt_sig    = cmd_rep;
        w_acc_sig    = cmd_load ? cmd_dato : r_acc;
        w_carry_sig  = 1'b0;
`ifdef CORRIMIENTO_OVF_EN
        w_ovf_sig    = 1'b0;
`endif
        w_estado_sig = EXEC;
      end
      EXEC: begin
        w_acc_sig    = w_shift;
        w_carry_sig  = w_carry_it;
`ifdef CORRIMIENTO_OVF_EN
        w_ovf_sig    = r_ovf | w_ovf_it;
`endif
        w_estado_sig = (r_cnt == '0) ? DONE : EXEC;
        w_cnt_sig    = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
      end
      DONE: w_estado_sig = res_ready ? IDLE : DONE;
      default: w_estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
      r_acc    <= '0;
      r_op     <= OP_TRANSFER;
      r_d      <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
`ifdef CORRIMIENTO_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_estado <= w_estado_sig;
      r_acc    <= w_acc_sig;
      r_op     <= w_op_sig;
      r_d      <= w_d_sig;
      r_cnt    <= w_cnt_sig;
      r_carry  <= w_carry_sig;
`ifdef CORRIMIENTO_OVF_EN
      r_ovf    <= w_ovf_sig;
`endif
    end
  end

  assign cmd_ready = (r_estado == IDLE);
  assign res_valid = (r_estado == DONE);
  assign res_dato  = r_acc;
  assign res_carry = r_carry;
  assign res_cero  = (r_acc == '0);
`ifdef CORRIMIENTO_OVF_EN
  assign res_ovf   = r_ovf;
`endif
endmodule
